// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/bram_sync.sv
// Single-clock simple-dual-port RAM with a registered read port, written to map onto block RAM.
module bram_sync
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it can map onto block RAM, and it is written with <= so the
    // same-edge read returns the old word, matching the RAM primitive.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with standard or first-word-fall-through output, runtime almost-full/empty
// thresholds and sticky overflow/underflow flags.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    input  logic                  err_clr,
    input  logic [ADDR_WIDTH:0]   almost_full_thresh,
    input  logic [ADDR_WIDTH:0]   almost_empty_thresh,
    output logic [ADDR_WIDTH:0]   fifo_count
);

    localparam int              CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   DEPTH   = CW'(fifo_depth(ADDR_WIDTH));
    localparam bit              IS_FWFT = (FWFT == FIFO_MODE_FWFT);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         mem_count;
    logic                  bq_valid;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] bram_q;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  fetch;
    logic                  out_load;

    bram_sync #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bram (
        .clk    (clk),
        .wr_addr(wr_ptr),
        .wr_data(wr_data),
        .wr_en  (wr_fire),
        .rd_addr(rd_addr),
        .rd_data(bram_q)
    );

    // NOTE: every signal here is assigned on every pass through the block, so no latch is inferred.
    always_comb begin
        full     = (count_q == DEPTH);
        empty    = IS_FWFT ? !out_valid : (count_q == '0);
        wr_fire  = wr_en && !full;
        rd_fire  = rd_en && !empty;
        // The RAM output stage feeds the output register when it is free or being drained this cycle.
        out_load = IS_FWFT ? (bq_valid && (!out_valid || rd_fire)) : bq_valid;
        fetch    = IS_FWFT ? ((mem_count != '0) && (!bq_valid || out_load)) : rd_fire;
        // Without a fetch the RAM re-reads the last fetched slot so a parked word stays stable.
        rd_addr  = fetch ? rd_ptr : rd_ptr - ADDR_WIDTH'(1);
        almost_full  = (count_q >= almost_full_thresh);
        almost_empty = (count_q <= almost_empty_thresh);
    end

    assign rd_data    = out_data;
    assign rd_valid   = out_valid;
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            mem_count <= '0;
            bq_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end

            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            // Words still sitting in the RAM, not yet moved toward the output.
            case ({wr_fire, fetch})
                2'b10:   mem_count <= mem_count + CW'(1);
                2'b01:   mem_count <= mem_count - CW'(1);
                default: mem_count <= mem_count;
            endcase

            bq_valid <= fetch || (bq_valid && !out_load);
            if (out_load) begin
                out_data <= bram_q;
            end
            out_valid <= IS_FWFT ? (out_load || (out_valid && !rd_fire)) : out_load;

            // A new error wins over a simultaneous clear.
            overflow  <= (wr_en && full)  || (overflow  && !err_clr);
            underflow <= (rd_en && empty) || (underflow && !err_clr);
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: one standard-mode and one FWFT instance, each walked through the same
// scenario list with hand-computed expectations.
module tb_fifo_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       wr_en;
    logic [1:0]       rd_en;
    logic [1:0]       err_clr;
    logic [1:0][15:0] wr_data;
    logic [1:0][15:0] rd_data;
    logic [1:0][4:0]  af_th;
    logic [1:0][4:0]  ae_th;
    logic [1:0][4:0]  fifo_count;
    logic [1:0]       full;
    logic [1:0]       almost_full;
    logic [1:0]       overflow;
    logic [1:0]       rd_valid;
    logic [1:0]       empty;
    logic [1:0]       almost_empty;
    logic [1:0]       underflow;

    int checks = 0;
    int errors = 0;
    int m      = 0;

    fifo_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst[0]), .wr_data(wr_data[0]), .wr_en(wr_en[0]), .full(full[0]),
        .almost_full(almost_full[0]), .overflow(overflow[0]), .rd_en(rd_en[0]), .rd_data(rd_data[0]),
        .rd_valid(rd_valid[0]), .empty(empty[0]), .almost_empty(almost_empty[0]),
        .underflow(underflow[0]), .err_clr(err_clr[0]), .almost_full_thresh(af_th[0]),
        .almost_empty_thresh(ae_th[0]), .fifo_count(fifo_count[0])
    );

    fifo_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst[1]), .wr_data(wr_data[1]), .wr_en(wr_en[1]), .full(full[1]),
        .almost_full(almost_full[1]), .overflow(overflow[1]), .rd_en(rd_en[1]), .rd_data(rd_data[1]),
        .rd_valid(rd_valid[1]), .empty(empty[1]), .almost_empty(almost_empty[1]),
        .underflow(underflow[1]), .err_clr(err_clr[1]), .almost_full_thresh(af_th[1]),
        .almost_empty_thresh(ae_th[1]), .fifo_count(fifo_count[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s mode=%0d observed=%0h expected=%0h", tag, m, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst[m] = 1'b1;
        tick();
        rst[m] = 1'b0;
    endtask

    task automatic run_fill_overflow();
        do_reset();
        check("reset_count", fifo_count[m], 0);
        check("reset_empty", empty[m], 1);
        check("reset_full", full[m], 0);
        check("reset_valid", rd_valid[m], 0);
        check("reset_data", rd_data[m], 0);
        check("reset_errs", {overflow[m], underflow[m]}, 0);
        for (int i = 0; i < 16; i++) begin
            wr_en[m] = 1'b1;
            wr_data[m] = 16'(i);
            tick();
            check("fill_count", fifo_count[m], i + 1);
            check("fill_full", full[m], (i == 15));
            check("fill_afull", almost_full[m], (i + 1 >= 14));
            check("fill_aempty", almost_empty[m], (i + 1 <= 2));
        end
        wr_data[m] = 16'hDEAD;
        tick();
        check("ovf_set", overflow[m], 1);
        check("ovf_count", fifo_count[m], 16);
        wr_en[m] = 1'b0;
        err_clr[m] = 1'b1;
        tick();
        err_clr[m] = 1'b0;
        check("ovf_clr", overflow[m], 0);
        wr_en[m] = 1'b1;
        err_clr[m] = 1'b1;
        tick();
        wr_en[m] = 1'b0;
        err_clr[m] = 1'b0;
        check("ovf_set_wins", overflow[m], 1);
        check("ovf_count2", fifo_count[m], 16);
        err_clr[m] = 1'b1;
        tick();
        err_clr[m] = 1'b0;
        check("ovf_clr2", overflow[m], 0);
        af_th[m] = 5'd17;
        #1;
        check("afull_over_depth", almost_full[m], 0);
        af_th[m] = 5'd16;
        #1;
        check("afull_at_depth", almost_full[m], 1);
        af_th[m] = 5'd14;
    endtask

    task automatic run_drain();
        if (m == 0) begin
            rd_en[m] = 1'b1;
            for (int t = 1; t <= 16; t++) begin
                tick();
                check("drain_count", fifo_count[m], 16 - t);
                check("drain_valid", rd_valid[m], (t >= 2));
                if (t >= 2) check("drain_data", rd_data[m], t - 2);
            end
            rd_en[m] = 1'b0;
            tick();
            check("drain_last_valid", rd_valid[m], 1);
            check("drain_last_data", rd_data[m], 16'h000F);
            check("drain_empty", empty[m], 1);
            tick();
            check("drain_strobe_end", rd_valid[m], 0);
            check("drain_data_hold", rd_data[m], 16'h000F);
        end else begin
            for (int i = 0; i < 16; i++) begin
                check("drain_nonempty", empty[m], 0);
                check("drain_data", rd_data[m], i);
                rd_en[m] = 1'b1;
                tick();
                check("drain_count", fifo_count[m], 15 - i);
            end
            rd_en[m] = 1'b0;
            check("drain_empty", empty[m], 1);
            check("drain_valid_low", rd_valid[m], 0);
        end
    endtask

    task automatic run_underflow();
        rd_en[m] = 1'b1;
        tick();
        rd_en[m] = 1'b0;
        check("udf_set", underflow[m], 1);
        check("udf_count", fifo_count[m], 0);
        check("udf_valid", rd_valid[m], 0);
        tick();
        check("udf_valid_next", rd_valid[m], 0);
        check("udf_sticky", underflow[m], 1);
        err_clr[m] = 1'b1;
        tick();
        err_clr[m] = 1'b0;
        check("udf_clr", underflow[m], 0);
    endtask

    task automatic run_wrap();
        for (int i = 0; i < 8; i++) begin
            wr_en[m] = 1'b1;
            wr_data[m] = 16'h0100 + 16'(i);
            tick();
        end
        check("wrap_count0", fifo_count[m], 8);
        for (int j = 0; j < 20; j++) begin
            wr_en[m] = 1'b1;
            wr_data[m] = 16'h0108 + 16'(j);
            rd_en[m] = 1'b1;
            if (m == 1) begin
                check("wrap_nonempty", empty[m], 0);
                check("wrap_data", rd_data[m], 16'h0100 + j);
            end
            tick();
            check("wrap_count", fifo_count[m], 8);
            if (m == 0 && j >= 1) begin
                check("wrap_valid", rd_valid[m], 1);
                check("wrap_data", rd_data[m], 16'h0100 + j - 1);
            end
        end
        wr_en[m] = 1'b0;
        rd_en[m] = 1'b0;
        tick();
        if (m == 0) check("wrap_data_last", rd_data[m], 16'h0113);
        else check("wrap_data_next", rd_data[m], 16'h0114);
    endtask

    task automatic run_thresholds();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            wr_en[m] = 1'b1;
            wr_data[m] = 16'h0200 + 16'(i);
            tick();
        end
        wr_en[m] = 1'b0;
        check("th_count", fifo_count[m], 12);
        check("th_afull_14", almost_full[m], 0);
        af_th[m] = 5'd10;
        #1;
        check("th_afull_10", almost_full[m], 1);
        check("th_aempty_2", almost_empty[m], 0);
        ae_th[m] = 5'd12;
        #1;
        check("th_aempty_12", almost_empty[m], 1);
        af_th[m] = 5'd14;
        ae_th[m] = 5'd2;
    endtask

    task automatic single_word(input logic [15:0] data);
        wr_en[m] = 1'b1;
        wr_data[m] = data;
        tick();
        wr_en[m] = 1'b0;
        check("sw_count", fifo_count[m], 1);
        if (m == 1) begin
            check("sw_empty_n1", empty[m], 1);
            tick();
            check("sw_empty_n2", empty[m], 1);
            tick();
            check("sw_shown", empty[m], 0);
            check("sw_data", rd_data[m], data);
            check("sw_valid", rd_valid[m], 1);
            rd_en[m] = 1'b1;
            tick();
            rd_en[m] = 1'b0;
        end else begin
            check("sw_empty", empty[m], 0);
            rd_en[m] = 1'b1;
            tick();
            rd_en[m] = 1'b0;
            check("sw_valid_early", rd_valid[m], 0);
            tick();
            check("sw_valid", rd_valid[m], 1);
            check("sw_data", rd_data[m], data);
        end
        check("sw_popped", empty[m], 1);
        check("sw_count_end", fifo_count[m], 0);
    endtask

    task automatic run_latency_reset();
        do_reset();
        single_word(16'h1234);
        rd_en[m] = 1'b1;
        tick();
        rd_en[m] = 1'b0;
        check("rb_udf_pre", underflow[m], 1);
        for (int i = 0; i < 4; i++) begin
            wr_en[m] = 1'b1;
            wr_data[m] = 16'h0500 + 16'(i);
            rst[m] = (i == 3);
            tick();
        end
        rst[m] = 1'b0;
        wr_en[m] = 1'b0;
        check("rb_count", fifo_count[m], 0);
        check("rb_empty", empty[m], 1);
        check("rb_errs", {overflow[m], underflow[m]}, 0);
        check("rb_data", rd_data[m], 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rb_stay_empty", empty[m], 1);
            check("rb_no_valid", rd_valid[m], 0);
        end
        single_word(16'hBEEF);
    endtask

    initial begin
        rst     = 2'b00;
        wr_en   = 2'b00;
        rd_en   = 2'b00;
        err_clr = 2'b00;
        wr_data = '0;
        af_th   = {5'd14, 5'd14};
        ae_th   = {5'd2, 5'd2};
        tick();
        for (int k = 0; k < 2; k++) begin
            m = k;
            run_fill_overflow();
            run_drain();
            run_underflow();
            run_wrap();
            run_thresholds();
            run_latency_reset();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
